// File: rtl/clock_display_pkg.sv
// Shared constants and helpers for seven-segment time displays.
// Segment patterns are active-low, ordered a..g from bit 6 down to bit 0.
package clock_display_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [2:0] {
      DIG_SEC_U = 3'd0,
      DIG_SEC_T = 3'd1,
      DIG_MIN_U = 3'd2,
      DIG_MIN_T = 3'd3,
      DIG_HRS_U = 3'd4,
      DIG_HRS_T = 3'd5
   } digit_e;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
   } bcd_t;

   // Compare-subtract split, exact for v <= 59; larger values are shown as dashes anyway.
   function automatic bcd_t bcd_split(input logic [5:0] v);
      logic [5:0] r;
      logic [3:0] t;
      bcd_t       res;
      r = v;
      t = 4'd0;
      for (int k = 0; k < 5; k++) begin
         if (r >= 6'd10) begin
            r = r - 6'd10;
            t = t + 4'd1;
         end
      end
      res.tens  = t;
      res.units = r[3:0];
      return res;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern, with dash and blank overrides.
module seg7_decode
   import clock_display_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      seg_n_o = SEG_BLANK;
      if (dash_i) begin
         seg_n_o = SEG_DASH;
      end else if (!blank_i) begin
         case (digit_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed hh.mm.ss display driver; each frame is drawn from one
// snapshot of the clock counter taken at the digit-0 wrap.
module clock_display_scan
   import clock_display_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic [3:0] hrs,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [5:0] an_n,
   output logic       frame_start
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt_q;
   digit_e        idx_q, idx_d;
   logic          started_q;
   logic [3:0]    hrs_s_q;
   logic [5:0]    min_s_q, sec_s_q;
   logic [6:0]    seg_n_q;
   logic          dp_n_q;
   logic [5:0]    an_n_q;
   logic          frame_start_q;

   logic          tick, wrap;
   logic [3:0]    h_src;
   logic [5:0]    m_src, s_src;
   logic          h_ok, m_ok, s_ok;
   bcd_t          h_bcd, m_bcd, s_bcd;
   logic [3:0]    dig_d;
   logic          dash_d, blank_d;
   logic [6:0]    seg_n_d;

   assign tick = en && (cnt_q == CW'(SCAN_DIV - 1));
   // The first tick after reset is treated as a wrap so frame 0 starts on digit 0.
   assign wrap = tick && (!started_q || idx_q == DIG_HRS_T);

   always_comb begin
      idx_d = idx_q;
      if (wrap)
         idx_d = DIG_SEC_U;
      else if (tick)
         idx_d = digit_e'(idx_q + 3'd1);
   end

   // On the wrap edge digit 0 is decoded from the live inputs being captured.
   assign h_src = wrap ? hrs : hrs_s_q;
   assign m_src = wrap ? min : min_s_q;
   assign s_src = wrap ? sec : sec_s_q;

   assign h_ok  = (h_src <= 4'd12);
   assign m_ok  = (m_src <= 6'd59);
   assign s_ok  = (s_src <= 6'd59);
   assign h_bcd = bcd_split({2'b00, h_src});
   assign m_bcd = bcd_split(m_src);
   assign s_bcd = bcd_split(s_src);

   always_comb begin
      dig_d   = 4'd0;
      dash_d  = 1'b0;
      blank_d = 1'b0;
      case (idx_d)
         DIG_SEC_U: begin dig_d = s_bcd.units; dash_d = !s_ok; end
         DIG_SEC_T: begin dig_d = s_bcd.tens;  dash_d = !s_ok; end
         DIG_MIN_U: begin dig_d = m_bcd.units; dash_d = !m_ok; end
         DIG_MIN_T: begin dig_d = m_bcd.tens;  dash_d = !m_ok; end
         DIG_HRS_U: begin dig_d = h_bcd.units; dash_d = !h_ok; end
         DIG_HRS_T: begin
            dig_d   = h_bcd.tens;
            dash_d  = !h_ok;
            blank_d = (h_bcd.tens == 4'd0);
         end
         default: ;
      endcase
   end

   seg7_decode u_seg7_decode (
      .digit_i (dig_d),
      .blank_i (blank_d),
      .dash_i  (dash_d),
      .seg_n_o (seg_n_d)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q         <= '0;
         idx_q         <= DIG_SEC_U;
         started_q     <= 1'b0;
         hrs_s_q       <= '0;
         min_s_q       <= '0;
         sec_s_q       <= '0;
         seg_n_q       <= SEG_BLANK;
         dp_n_q        <= 1'b1;
         an_n_q        <= '1;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= wrap;
         if (en)
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
         if (tick) begin
            idx_q     <= idx_d;
            started_q <= 1'b1;
            seg_n_q   <= seg_n_d;
            dp_n_q    <= !(idx_d == DIG_MIN_U || idx_d == DIG_HRS_U);
            an_n_q    <= ~(6'd1 << idx_d);
         end else if (!en) begin
            an_n_q <= '1;
         end else if (started_q) begin
            an_n_q <= ~(6'd1 << idx_q);
         end
         if (wrap) begin
            hrs_s_q <= hrs;
            min_s_q <= min;
            sec_s_q <= sec;
         end
      end
   end

   assign seg_n       = seg_n_q;
   assign dp_n        = dp_n_q;
   assign an_n        = an_n_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4: frame vectors plus
// snapshot, enable and mid-frame reset sequences.
module tb_clock_display_scan;

   localparam int SD = 4;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] DA = 7'b1111110;
   localparam logic [6:0] BL = 7'b1111111;

   typedef struct packed {
      logic [3:0]      h;
      logic [5:0]      m;
      logic [5:0]      s;
      logic [5:0][6:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       en;
   logic [3:0] hrs;
   logic [5:0] min;
   logic [5:0] sec;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [5:0] an_n;
   logic       frame_start;

   int checks = 0;
   int errors = 0;
   vec_t vecs [6];

   clock_display_scan #(.SCAN_DIV(SD)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .hrs         (hrs),
      .min         (min),
      .sec         (sec),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .an_n        (an_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h at %0t", name, act, $time);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      while (frame_start !== 1'b1 && n < 60) begin
         step(1);
         n++;
      end
      chk("frame_start_seen", {31'd0, frame_start}, 32'd1);
   endtask

   task automatic run_frame(input vec_t v);
      hrs = v.h;
      min = v.m;
      sec = v.s;
      step(1);
      wait_frame();
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("an_n[%0d:%0d]", v.h, k), {26'd0, an_n}, {26'd0, ~(6'd1 << k)});
         chk($sformatf("seg_n[%0d:%0d:%0d:%0d]", v.h, v.m, v.s, k), {25'd0, seg_n}, {25'd0, v.exp[k]});
         chk($sformatf("dp_n[%0d]", k), {31'd0, dp_n}, (k == 2 || k == 4) ? 32'd0 : 32'd1);
         step(SD);
      end
   endtask

   initial begin
      vecs[0] = '{h: 4'd0,  m: 6'd0,  s: 6'd0,  exp: {BL, S0, S0, S0, S0, S0}};
      vecs[1] = '{h: 4'd10, m: 6'd25, s: 6'd37, exp: {S1, S0, S2, S5, S3, S7}};
      vecs[2] = '{h: 4'd9,  m: 6'd0,  s: 6'd5,  exp: {BL, S9, S0, S0, S0, S5}};
      vecs[3] = '{h: 4'd12, m: 6'd59, s: 6'd59, exp: {S1, S2, S5, S9, S5, S9}};
      vecs[4] = '{h: 4'd13, m: 6'd60, s: 6'd42, exp: {DA, DA, DA, DA, S4, S2}};
      vecs[5] = '{h: 4'd0,  m: 6'd59, s: 6'd60, exp: {BL, S0, S5, S9, DA, DA}};

      rstn = 1'b1;
      en   = 1'b1;
      hrs  = 4'd0;
      min  = 6'd0;
      sec  = 6'd0;
      #2 rstn = 1'b0;
      #10;
      chk("rst_an_n", {26'd0, an_n}, 32'h3f);
      chk("rst_seg_n", {25'd0, seg_n}, 32'h7f);
      chk("rst_dp_n", {31'd0, dp_n}, 32'd1);
      chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
      @(posedge clk);
      #1 rstn = 1'b1;

      // Blank through edge 3, digit 0 on edge 4.
      for (int e = 1; e <= 3; e++) begin
         step(1);
         chk($sformatf("pre_an_n_e%0d", e), {26'd0, an_n}, 32'h3f);
         chk($sformatf("pre_fs_e%0d", e), {31'd0, frame_start}, 32'd0);
      end
      step(1);
      chk("first_an_n", {26'd0, an_n}, 32'h3e);
      chk("first_seg_n", {25'd0, seg_n}, {25'd0, S0});
      chk("first_fs", {31'd0, frame_start}, 32'd1);
      step(1);
      chk("fs_one_cycle", {31'd0, frame_start}, 32'd0);

      for (int i = 0; i < 6; i++)
         run_frame(vecs[i]);

      // Snapshot: change sec while digit 3 is showing.
      hrs = 4'd10; min = 6'd25; sec = 6'd37;
      step(1);
      wait_frame();
      chk("snap_d0", {25'd0, seg_n}, {25'd0, S7});
      step(3 * SD);
      chk("snap_an3", {26'd0, an_n}, 32'h37);
      sec = 6'd38;
      step(SD);
      chk("snap_d4", {25'd0, seg_n}, {25'd0, S0});
      step(SD);
      chk("snap_d5", {25'd0, seg_n}, {25'd0, S1});
      step(SD);
      chk("snap_fs", {31'd0, frame_start}, 32'd1);
      chk("snap_new_d0", {25'd0, seg_n}, {25'd0, S8});

      // Enable low while digit 2 is showing.
      step(2 * SD);
      chk("en_an2", {26'd0, an_n}, 32'h3b);
      en = 1'b0;
      step(1);
      chk("en_off_an", {26'd0, an_n}, 32'h3f);
      step(9);
      chk("en_off_hold_an", {26'd0, an_n}, 32'h3f);
      chk("en_off_fs", {31'd0, frame_start}, 32'd0);
      en = 1'b1;
      step(1);
      chk("en_resume_an", {26'd0, an_n}, 32'h3b);
      chk("en_resume_seg", {25'd0, seg_n}, {25'd0, S5});
      chk("en_resume_fs", {31'd0, frame_start}, 32'd0);
      step(3);
      chk("en_next_an", {26'd0, an_n}, 32'h37);

      // Mid-frame async reset.
      step(2);
      rstn = 1'b0;
      #1;
      chk("mid_rst_an", {26'd0, an_n}, 32'h3f);
      chk("mid_rst_seg", {25'd0, seg_n}, 32'h7f);
      chk("mid_rst_dp", {31'd0, dp_n}, 32'd1);
      #2 rstn = 1'b1;
      step(3);
      chk("restart_blank_an", {26'd0, an_n}, 32'h3f);
      step(1);
      chk("restart_an", {26'd0, an_n}, 32'h3e);
      chk("restart_fs", {31'd0, frame_start}, 32'd1);
      chk("restart_seg", {25'd0, seg_n}, {25'd0, S8});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Time-multiplexed six-digit seven-segment display driver. It reads the binary hours/minutes/seconds outputs of the digital clock counter and converts each field to two BCD digits. It then scans the digits one at a time onto a common-anode display. It sits between the clock counter and the board's display pins, and is the read side of the clock's time outputs.

## Interface
- SCAN_DIV, 1000: clk cycles each digit is held; legal range ≥ 2.
- clk  input  1  system clock, rising-edge.
- rstn  input  1  reset, asynchronous, active-low.
- en  input  1  display enable; low blanks all anodes and freezes scanning.
- hrs  input  4  binary hours; valid range 0..12.
- min  input  6  binary minutes; valid range 0..59.
- sec  input  6  binary seconds; valid range 0..59.
- seg_n  output  7  segments, active-low; seg_n[6]=a, seg_n[5]=b, …, seg_n[0]=g.
- dp_n  output  1  decimal point, active-low.
- an_n  output  6  digit anodes, active-low, one-hot-low when active.
- frame_start  output  1  one-cycle pulse when digit 0 is driven from a new snapshot.

## Operation
- Prescaler cnt runs 0..SCAN_DIV-1 while en=1. tick = (cnt==SCAN_DIV-1) && en.
- Digit index idx runs 0..5 and advances by 1 on each tick, wrapping 5→0.
- Digit map:
  - idx 0: sec units
  - idx 1: sec tens
  - idx 2: min units
  - idx 3: min tens
  - idx 4: hrs units
  - idx 5: hrs tens
- Snapshot registers (hrs_s, min_s, sec_s) load the live inputs on the tick that moves idx to 0. Segment data for that digit-0 slot comes from the live inputs at that edge, so the snapshot and the displayed digit are consistent. All six digits of a frame come from one snapshot, so there is no tearing.
- BCD split: tens = v/10 and units = v%10 for v ≤ 59, by a compare-subtract chain; no divider.
- Out-of-range field (hrs>12, min>59 or sec>59): both digits of that field show a dash, seg_n=7'b1111110.
- Leading-zero blank: when hrs tens = 0, digit 5 has seg_n=7'b1111111 but its anode is still asserted.
- dp_n=0 on idx 4 and idx 2, giving the hh.mm.ss separators; dp_n=1 otherwise.
- an_n = ~(6'b1 << idx) while en=1.
- en low: an_n=6'b111111 from the next edge; cnt and idx hold. On en high, scanning resumes from the held cnt/idx with no snapshot reload.

## Timing
- Reset values, async on rstn low:
  - cnt=0, idx=0, snapshot=0
  - seg_n=7'b1111111, dp_n=1, an_n=6'b111111, frame_start=0
- After reset, the first tick (edge SCAN_DIV) counts as a 5→0 wrap. It loads the snapshot, drives digit 0 and pulses frame_start.
- All outputs are registered. an_n, seg_n and dp_n change together on the tick edge. There is no cycle where an anode is active with the previous digit's segments.
- frame_start is high for exactly the one cycle following the wrap edge.
- Each digit is held SCAN_DIV cycles. Frame period is 6·SCAN_DIV cycles.
- Input changes between wraps have no effect until the next wrap.
- rstn asserted mid-frame blanks the outputs immediately, asynchronously. Deassertion restarts as after power-up.

## Structure
- Package clock_display_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (active-low a..g)
  - NUM_DIGITS=6
  - the digit-index enum DIG_SEC_U..DIG_HRS_T
- Sub-module seg7_decode (combinational): 4-bit BCD digit plus blank and dash flags in, seg_n out. Shared with future display blocks.
- Top level holds the prescaler, idx counter, snapshot registers, BCD split and output registers.

## Test plan
All scenarios run with SCAN_DIV=4.
- Reset, then hrs=0, min=0, sec=0 → outputs blank through cycle 3. At edge 4: an_n=6'b111110, seg_n=7'b0000001 ("0"), frame_start pulses.
- hrs=10, min=25, sec=37 → across one frame, idx 0..5 show 7,3,5,2,0,1; digit 0 seg_n=7'b0001111. dp_n=0 only on idx 2 and 4.
- sec changes 37→38 while idx=3 → digits 4,5 unchanged in the current frame; "8" first appears on digit 0 at the next frame_start.
- hrs=9 → digit 5 has seg_n=7'b1111111 with an_n=6'b011111. hrs=12 → digits 5,4 show 1,2.
- min=60 and hrs=13 → digits 3,2 and 5,4 show seg_n=7'b1111110. The sec digits stay normal.
- en low at idx=2 → an_n=6'b111111 next cycle; idx held at 2 for 10 cycles, then resumes at 2 on en high. rstn pulse mid-frame → immediate blank, restart at idx 0.
